// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and constants for the two-requester round-robin mux arbiter.
//   arb_state_t : arbiter FSM state (IDLE, GRANT_A, GRANT_B)
//   SEL_A/SEL_B : select encoding used on out_sel and the priority pointer
// -----------------------------------------------------------------------------
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : mux_arb_pkg

// File: rtl/mux_out_stage.sv
// -----------------------------------------------------------------------------
// mux_out_stage
// One-entry registered valid/ready stage holding {sel, last, data}.
//   clk, rst       : clock, asynchronous active-high reset
//   i_load         : capture i_sel/i_last/i_data on this edge (upstream beat
//                    accepted); the caller only loads when the entry is free
//                    or being drained in the same cycle
//   i_sel/i_last/i_data : beat to capture
//   i_ready        : downstream accepts the held beat
//   o_valid/o_sel/o_last/o_data : held beat presented downstream
// -----------------------------------------------------------------------------
module mux_out_stage
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_sel,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic              o_sel,
    output logic              o_last,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic              r_sel;
    logic              r_last;
    logic [DATA_W-1:0] r_data;

    // NOTE: payload registers are reset too (not just valid) so the outputs
    // show defined zeros after reset; they are plain flops, not a memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sel   <= SEL_A;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            // A load wins over a drain: the new beat replaces the one leaving.
            r_valid <= 1'b1;
            r_sel   <= i_sel;
            r_last  <= i_last;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            // Payload is left untouched so out_sel/out_data only move on a load.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_sel   = r_sel;
    assign o_last  = r_last;
    assign o_data  = r_data;

endmodule : mux_out_stage

// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
// Two-requester round-robin arbiter sharing one 2:1 data mux between sources
// A and B. Grant is held for a whole packet (until the last beat is accepted),
// then priority passes to the other side. The selected beat is registered in a
// one-entry output stage.
//   clk, rst                     : clock, asynchronous active-high reset
//   a_valid/a_data/a_last/a_ready: source A beat handshake
//   b_valid/b_data/b_last/b_ready: source B beat handshake
//   out_valid/out_data/out_last/out_sel/out_ready : downstream handshake
//   busy                         : a grant is currently held
//   pkt_cnt_a/pkt_cnt_b          : wrapping completed-packet counters
// -----------------------------------------------------------------------------
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_sel,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_cnt_a,
    output logic [CNT_W-1:0]  pkt_cnt_b
);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic             r_prio;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    logic              w_stage_free;
    logic              w_a_acc;
    logic              w_b_acc;
    logic              w_a_done;
    logic              w_b_done;
    logic              w_load;
    logic              w_load_sel;
    logic              w_load_last;
    logic [DATA_W-1:0] w_load_data;

    // The output entry can take a beat when empty or when it drains this cycle;
    // this is what gives 1 beat/cycle streaming while out_ready stays high.
    assign w_stage_free = !out_valid || out_ready;

    assign a_ready = (r_state == GRANT_A) && w_stage_free;
    assign b_ready = (r_state == GRANT_B) && w_stage_free;

    assign w_a_acc  = a_valid && a_ready;
    assign w_b_acc  = b_valid && b_ready;
    assign w_a_done = w_a_acc && a_last;
    assign w_b_done = w_b_acc && b_last;

    // At most one side is granted, so the mux select is simply "B accepted".
    assign w_load      = w_a_acc || w_b_acc;
    assign w_load_sel  = w_b_acc ? SEL_B : SEL_A;
    assign w_load_last = w_b_acc ? b_last : a_last;
    assign w_load_data = w_b_acc ? b_data : a_data;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (a_valid && (!b_valid || r_prio == SEL_A)) begin
                    w_state_next = GRANT_A;
                end else if (b_valid) begin
                    w_state_next = GRANT_B;
                end
            end
            // Handing over straight to a waiting peer avoids an IDLE bubble
            // on back-to-back alternation.
            GRANT_A: if (w_a_done) w_state_next = b_valid ? GRANT_B : IDLE;
            GRANT_B: if (w_b_done) w_state_next = a_valid ? GRANT_A : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_prio  <= SEL_A;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_a_done) begin
                r_cnt_a <= r_cnt_a + CNT_W'(1);
                r_prio  <= SEL_B;
            end
            if (w_b_done) begin
                r_cnt_b <= r_cnt_b + CNT_W'(1);
                r_prio  <= SEL_A;
            end
        end
    end

    mux_out_stage #(
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_sel   (w_load_sel),
        .i_last  (w_load_last),
        .i_data  (w_load_data),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_sel   (out_sel),
        .o_last  (out_last),
        .o_data  (out_data)
    );

    assign busy      = (r_state != IDLE);
    assign pkt_cnt_a = r_cnt_a;
    assign pkt_cnt_b = r_cnt_b;

endmodule : rr_mux_arbiter

// File: tb/tb_rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter
// Self-checking bench: directed scenarios plus a randomized phase, all compared
// cycle by cycle against a behavioural model of the arbiter's rules.
// -----------------------------------------------------------------------------
module tb_rr_mux_arbiter;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_last;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_last;
    logic              b_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_sel;
    logic              out_ready;
    logic              busy;
    logic [CNT_W-1:0]  pkt_cnt_a;
    logic [CNT_W-1:0]  pkt_cnt_b;

    rr_mux_arbiter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .busy      (busy),
        .pkt_cnt_a (pkt_cnt_a),
        .pkt_cnt_b (pkt_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vectors = 0;
    int n_miscompares = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: who holds the grant (0 nobody, 1 A, 2 B); next_b: B is next in turn.
    int        m_owner;
    bit        m_next_b;
    bit        m_ov;
    bit        m_ol;
    bit        m_os;
    int        m_od;
    int        m_cnt_a;
    int        m_cnt_b;
    bit        acc_a;
    bit        acc_b;
    int        cyc;
    int        obs_data[$];
    int        obs_sel[$];

    function automatic void model_reset();
        m_owner  = 0;
        m_next_b = 0;
        m_ov     = 0;
        m_ol     = 0;
        m_os     = 0;
        m_od     = 0;
        m_cnt_a  = 0;
        m_cnt_b  = 0;
        acc_a    = 0;
        acc_b    = 0;
    endfunction

    function automatic int obs_at(input int i);
        return (i < obs_data.size()) ? obs_data[i] : 32'hDEAD;
    endfunction

    // Called just after a rising edge with inputs already driven: compares
    // the DUT at the falling edge, then advances the model across the next edge.
    task automatic step();
        bit free, ea, eb;
        int n_owner, n_od, n_cnt_a, n_cnt_b;
        bit n_next_b, n_ov, n_ol, n_os;
        @(negedge clk);
        free = !m_ov || out_ready;
        ea   = (m_owner == 1) && free;
        eb   = (m_owner == 2) && free;
        check("a_ready",   a_ready,   ea);
        check("b_ready",   b_ready,   eb);
        check("out_valid", out_valid, m_ov);
        check("out_data",  out_data,  m_od[7:0]);
        check("out_last",  out_last,  m_ol);
        check("out_sel",   out_sel,   m_os);
        check("busy",      busy,      m_owner != 0);
        check("pkt_cnt_a", pkt_cnt_a, m_cnt_a);
        check("pkt_cnt_b", pkt_cnt_b, m_cnt_b);
        if (out_valid && out_ready) begin
            obs_data.push_back(int'(out_data));
            obs_sel.push_back(int'(out_sel));
        end
        acc_a = a_valid && ea;
        acc_b = b_valid && eb;
        n_owner = m_owner; n_next_b = m_next_b;
        n_ov = m_ov; n_ol = m_ol; n_os = m_os; n_od = m_od;
        n_cnt_a = m_cnt_a; n_cnt_b = m_cnt_b;
        if (acc_a) begin
            n_ov = 1; n_od = int'(a_data); n_ol = a_last; n_os = 0;
        end else if (acc_b) begin
            n_ov = 1; n_od = int'(b_data); n_ol = b_last; n_os = 1;
        end else if (m_ov && out_ready) begin
            n_ov = 0;
        end
        if (m_owner == 0) begin
            if (a_valid && b_valid) n_owner = m_next_b ? 2 : 1;
            else if (a_valid)       n_owner = 1;
            else if (b_valid)       n_owner = 2;
        end else if (m_owner == 1 && acc_a && a_last) begin
            n_cnt_a  = (m_cnt_a + 1) % 256;
            n_next_b = 1;
            n_owner  = b_valid ? 2 : 0;
        end else if (m_owner == 2 && acc_b && b_last) begin
            n_cnt_b  = (m_cnt_b + 1) % 256;
            n_next_b = 0;
            n_owner  = a_valid ? 1 : 0;
        end
        @(posedge clk);
        #1;
        m_owner = n_owner; m_next_b = n_next_b;
        m_ov = n_ov; m_ol = n_ol; m_os = n_os; m_od = n_od;
        m_cnt_a = n_cnt_a; m_cnt_b = n_cnt_b;
        cyc++;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_data = '0; a_last = 0;
        b_valid = 0; b_data = '0; b_last = 0;
        out_ready = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        obs_data.delete();
        obs_sel.delete();
        cyc = 0;
    endtask

    int a_left, b_left, n_done, t_last_a, t_first_b, guard;

    initial begin
        rst = 1;
        idle_inputs();
        model_reset();

        // 1: single-beat A packet
        do_reset();
        a_valid = 1; a_data = 8'h3C; a_last = 1;
        guard = 0;
        do begin step(); guard++; end while (!acc_a && guard < 10);
        if (!acc_a) check("t1_timeout", 1, 0);
        check("t1_accept_cycle", guard, 2);
        a_valid = 0;
        step(); step();
        check("t1_out_data", obs_at(0), 32'h3C);
        check("t1_cnt_a", pkt_cnt_a, 1);
        check("t1_idle", busy, 0);

        // 2: both sources single-beat, strict alternation from A
        do_reset();
        a_valid = 1; a_data = 8'h11; a_last = 1;
        b_valid = 1; b_data = 8'h22; b_last = 1;
        repeat (8) step();
        check("t2_beat0", obs_at(0), 32'h11);
        check("t2_beat1", obs_at(1), 32'h22);
        check("t2_beat2", obs_at(2), 32'h11);
        check("t2_beat3", obs_at(3), 32'h22);
        check("t2_sel1", (obs_sel.size() > 1) ? obs_sel[1] : 9, 1);
        check("t2_sel2", (obs_sel.size() > 2) ? obs_sel[2] : 9, 0);
        // Streaming: after the first grant cycle, one beat leaves every cycle.
        check("t2_no_bubble", obs_data.size(), 6);

        // 3: 3-beat A packet holds off a waiting B
        do_reset();
        b_valid = 1; b_data = 8'h44; b_last = 1;
        a_valid = 1; a_data = 8'h01; a_last = 0;
        a_left = 0; t_last_a = -1; t_first_b = -1; guard = 0;
        while (t_first_b < 0 && guard < 20) begin
            step(); guard++;
            if (acc_a) begin
                a_left++;
                if (a_left == 3) begin t_last_a = cyc; a_valid = 0; end
                a_data = 8'(a_left + 1); a_last = (a_left == 2);
            end
            if (acc_b) begin t_first_b = cyc; b_valid = 0; end
        end
        if (t_first_b < 0) check("t3_timeout", 1, 0);
        step(); step();
        check("t3_beat0", obs_at(0), 32'h01);
        check("t3_beat2", obs_at(2), 32'h03);
        check("t3_beat3", obs_at(3), 32'h44);
        check("t3_b_immediate", t_first_b - t_last_a, 1);

        // 4: backpressure in the middle of a 6-beat A packet
        do_reset();
        a_valid = 1; a_data = 8'hA0; a_last = 0; a_left = 0; guard = 0;
        while (a_left < 6 && guard < 40) begin
            out_ready = !(cyc >= 3 && cyc < 7);
            step(); guard++;
            if (acc_a) begin
                a_left++;
                a_data = 8'(8'hA0 + a_left); a_last = (a_left == 5);
                if (a_left == 6) a_valid = 0;
            end
        end
        if (a_left < 6) check("t4_timeout", 1, 0);
        out_ready = 1;
        step(); step();
        check("t4_count", obs_data.size(), 6);
        for (int i = 0; i < 6; i++) check("t4_beat", obs_at(i), 32'hA0 + i);

        // 5: 256 single-beat A packets wrap the counter
        do_reset();
        a_valid = 1; a_last = 1; a_data = 8'h00; n_done = 0; guard = 0;
        while (n_done < 256 && guard < 1000) begin
            step(); guard++;
            if (acc_a) begin
                n_done++;
                a_data = 8'(n_done);
                if (n_done == 255) begin
                    a_valid = 0;
                    step();
                    check("t5_cnt_255", pkt_cnt_a, 255);
                    a_valid = 1;
                end
            end
        end
        if (n_done < 256) check("t5_timeout", 1, 0);
        a_valid = 0;
        step();
        check("t5_wrap", pkt_cnt_a, 0);

        // 6: async reset while B holds the grant with a stalled output beat
        do_reset();
        a_valid = 1; a_data = 8'h77; a_last = 1;
        b_valid = 1; b_data = 8'h5A; b_last = 0;
        guard = 0;
        do begin
            step(); guard++;
            if (acc_a) a_valid = 0;
        end while (!acc_b && guard < 10);
        if (!acc_b) check("t6_timeout", 1, 0);
        out_ready = 0;
        step();
        check("t6_pre_busy", busy, 1);
        check("t6_pre_valid", out_valid, 1);
        #3 rst = 1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_last", out_last, 0);
        check("t6_rst_sel", out_sel, 0);
        check("t6_rst_a_ready", a_ready, 0);
        check("t6_rst_b_ready", b_ready, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cnt_a", pkt_cnt_a, 0);
        check("t6_rst_cnt_b", pkt_cnt_b, 0);
        do_reset();
        a_valid = 1; a_data = 8'h66; a_last = 1;
        b_valid = 1; b_data = 8'h99; b_last = 1;
        repeat (4) step();
        check("t6_a_first", obs_at(0), 32'h66);
        check("t6_b_second", obs_at(1), 32'h99);

        // Randomized traffic: packets of 1..4 beats, random valid and out_ready.
        do_reset();
        a_left = $urandom_range(1, 4); b_left = $urandom_range(1, 4);
        a_data = 8'($urandom); b_data = 8'($urandom);
        a_last = (a_left == 1); b_last = (b_left == 1);
        for (int i = 0; i < 3000; i++) begin
            a_valid   = ($urandom_range(0, 9) < 7);
            b_valid   = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
            if (acc_a) begin
                a_left--;
                if (a_left == 0) a_left = $urandom_range(1, 4);
                a_data = 8'($urandom); a_last = (a_left == 1);
            end
            if (acc_b) begin
                b_left--;
                if (b_left == 0) b_left = $urandom_range(1, 4);
                b_data = 8'($urandom); b_last = (b_left == 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_rr_mux_arbiter

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Two-requester round-robin arbiter that shares one 2:1 data mux between sources A and B.
- Select convention: sel 0 = A, sel 1 = B.
- Each source sends packets of one or more beats over a valid/ready handshake.
- Grant is held for a whole packet, until the beat with last=1 is accepted.
- The selected beat is registered into a one-entry output stage that feeds the downstream consumer.

Parameters:
DATA_W, 8, width of the data bus for each source and for the output
CNT_W, 8, width of the per-source completed-packet counters

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-high
a_valid  in  1  source A beat valid
a_data  in  DATA_W  source A beat data
a_last  in  1  source A final beat of packet
a_ready  out  1  source A beat accepted when a_valid&&a_ready
b_valid  in  1  source B beat valid
b_data  in  DATA_W  source B beat data
b_last  in  1  source B final beat of packet
b_ready  out  1  source B beat accepted when b_valid&&b_ready
out_valid  out  1  output beat valid
out_data  out  DATA_W  output beat data
out_last  out  1  output final beat
out_sel  out  1  source of the output beat (0=A, 1=B)
out_ready  in  1  downstream accepts the output beat
busy  out  1  grant currently held (state != IDLE)
pkt_cnt_a  out  CNT_W  packets completed from A, wrapping
pkt_cnt_b  out  CNT_W  packets completed from B, wrapping

Behaviour:
- Reset values: state=IDLE, prio=A, out_valid=0, out_data=0, out_last=0, out_sel=0, pkt_cnt_a/b=0, a_ready/b_ready=0, busy=0.
- Reset asserted mid-packet: packet is abandoned and any held output beat is dropped.
- States: IDLE, GRANT_A, GRANT_B. The state is registered.
- IDLE:
  - Only one source valid → grant that source next cycle.
  - Both valid → grant the side named by prio.
  - Neither valid → stay in IDLE.
- GRANT_x:
  - x_ready = !out_valid || out_ready (combinational).
  - Non-granted ready = 0 always.
- Beat accepted on x_valid && x_ready:
  - Next edge loads out_data=x_data, out_last=x_last, out_sel=x, out_valid=1.
- Accepted beat with x_last=1:
  - pkt_cnt_x increments, wrapping 2^CNT_W-1 → 0.
  - prio ← the other side.
  - Next state is GRANT_other if other_valid is 1 this cycle, else IDLE. There is no bubble on back-to-back alternation.
- Granted source deasserts valid mid-packet: grant is held indefinitely and no other source is served.
- Latency:
  - Request from IDLE: grant 1 cycle later.
  - Accepted beat: appears on out_* 1 cycle after acceptance.
  - Full-throughput streaming: 1 beat/cycle while out_ready=1.
- Output stage:
  - Drain (out_valid && out_ready) with no new load → out_valid=0 next cycle.
  - Simultaneous drain and load → new beat is loaded and out_valid stays 1.
  - While out_valid && !out_ready: out_* hold stable and x_ready=0.
- out_sel changes only when a new beat is loaded, never while a beat is stalled.
- busy = (state != IDLE).

Decomposition:
- Package mux_arb_pkg:
  - typedef enum logic[1:0] arb_state_t {IDLE, GRANT_A, GRANT_B}
  - localparams SEL_A=1'b0, SEL_B=1'b1
- One sub-module, mux_out_stage: one-entry registered valid/ready stage holding {sel, last, data}, with the same clk/rst.
- Arbiter FSM, prio pointer and counters stay in the top module.

Test Plan:
1. Reset, then A only: single-beat packet a_data=8'h3C, last=1 → a_ready high 1 cycle after a_valid; out_data=3C, out_sel=0, out_last=1 next cycle; pkt_cnt_a=1; state returns to IDLE.
2. A and B both valid from reset with single-beat packets (A=11, B=22, repeated) → A granted first; output order 11,22,11,22; out_sel 0,1,0,1; no idle cycle between grants.
3. A sends a 3-beat packet (01,02,03 last) while B is valid throughout → B not granted until 03 is accepted; then B is granted immediately; b_ready=0 during the A packet.
4. Backpressure: out_ready=0 for 4 cycles during an A packet → out_data/out_sel stable, a_ready=0; resume out_ready=1 → no beat lost or duplicated.
5. 256 single-beat A packets → pkt_cnt_a wraps to 0.
6. Assert rst mid-packet during GRANT_B with out_valid=1 → all outputs go to reset values immediately, without waiting for a clock edge; after release, A-first priority is restored.
